// File: rtl/time_uart_tx.sv
// time_uart_tx: snapshots the current time and date and sends them as one
// 21-byte ASCII line "HH:MM:SS DD.MM.YYYY\r\n" over an 8N1 UART.
module time_uart_tx #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] time_in,
    input  logic [20:0] date_in,
    input  logic        send,
    input  logic        auto_en,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned DIV      = CLK_FREQ / BAUD;
    localparam int unsigned DivW     = $clog2(DIV + 1);
    localparam int unsigned NumBytes = 21;
    localparam logic [4:0]  LastIdx  = 5'(NumBytes - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StConv,
        StStart,
        StData,
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [2:0]        bit_q, bit_d;
    logic [4:0]        idx_q, idx_d;
    logic              pend_q, pend_d;
    logic              tx_q, tx_d;
    logic              busy_q;
    logic              done_q, done_d;
    logic [5:0]        sec_q;
    logic [16:0]       time_q;
    logic [20:0]       date_q;
    logic [7:0]        msg_q [NumBytes];
    logic [7:0]        msg_d [NumBytes];
    logic              req;
    logic              div_end;
    logic              stop_end;

    // One decimal digit of val at the given place value, as ASCII.
    function automatic logic [7:0] ascii_digit(input logic [11:0] val,
                                               input logic [11:0] place);
        logic [11:0] d;
        d = (val / place) % 12'd10;
        return 8'h30 + d[7:0];
    endfunction

    // send and a seconds change in the same cycle collapse into one request.
    assign req = send | (auto_en & (time_in[5:0] != sec_q));

    assign div_end = (div_q == DivW'(DIV - 1));
    // tx is registered and trails the FSM by one cycle, so the final stop
    // state holds one extra cycle to end busy/done with the stop bit on the line.
    assign stop_end = (idx_q == LastIdx) ? (div_q == DivW'(DIV)) : div_end;

    // Format the snapshot into the fixed ASCII line.
    always_comb begin
        logic [11:0] hour, mins, secs, day, month, year;
        hour  = 12'(time_q[16:12]);
        mins  = 12'(time_q[11:6]);
        secs  = 12'(time_q[5:0]);
        day   = 12'(date_q[20:16]);
        month = 12'(date_q[15:12]);
        year  = date_q[11:0];
        msg_d[0]  = ascii_digit(hour, 12'd10);
        msg_d[1]  = ascii_digit(hour, 12'd1);
        msg_d[2]  = 8'h3A;
        msg_d[3]  = ascii_digit(mins, 12'd10);
        msg_d[4]  = ascii_digit(mins, 12'd1);
        msg_d[5]  = 8'h3A;
        msg_d[6]  = ascii_digit(secs, 12'd10);
        msg_d[7]  = ascii_digit(secs, 12'd1);
        msg_d[8]  = 8'h20;
        msg_d[9]  = ascii_digit(day, 12'd10);
        msg_d[10] = ascii_digit(day, 12'd1);
        msg_d[11] = 8'h2E;
        msg_d[12] = ascii_digit(month, 12'd10);
        msg_d[13] = ascii_digit(month, 12'd1);
        msg_d[14] = 8'h2E;
        msg_d[15] = ascii_digit(year, 12'd1000);
        msg_d[16] = ascii_digit(year, 12'd100);
        msg_d[17] = ascii_digit(year, 12'd10);
        msg_d[18] = ascii_digit(year, 12'd1);
        msg_d[19] = 8'h0D;
        msg_d[20] = 8'h0A;
    end

    // Next-state logic: message sequencing, bit timing and request pending.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        pend_d  = pend_q | (req & (state_q != StIdle));
        done_d  = 1'b0;
        tx_d    = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (req || pend_q) begin
                    state_d = StLoad;
                    pend_d  = 1'b0;
                end
            end
            StLoad: state_d = StConv;
            StConv: begin
                state_d = StStart;
                div_d   = '0;
                bit_d   = '0;
                idx_d   = '0;
            end
            StStart: begin
                tx_d = 1'b0;
                if (div_end) begin
                    div_d   = '0;
                    state_d = StData;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StData: begin
                tx_d = msg_q[idx_q][bit_q];
                if (div_end) begin
                    div_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StStop: begin
                if (!stop_end) begin
                    div_d = div_q + 1'b1;
                end else if (idx_q != LastIdx) begin
                    div_d   = '0;
                    idx_d   = idx_q + 1'b1;
                    state_d = StStart;
                end else begin
                    div_d  = '0;
                    idx_d  = '0;
                    done_d = 1'b1;
                    // A pending or coincident request restarts without dropping busy.
                    if (req || pend_q) begin
                        state_d = StLoad;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sec_q   <= time_in[5:0];
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= done_d;
            sec_q   <= time_in[5:0];
        end
    end

    // Snapshot in LOAD, ASCII conversion registered in CONV.
    always_ff @(posedge clk) begin
        if (state_q == StLoad) begin
            time_q <= time_in;
            date_q <= date_in;
        end
        if (state_q == StConv) begin
            msg_q <= msg_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_time_uart_tx.sv
// tb_time_uart_tx: directed and randomized checks of time_uart_tx with a
// UART receiver and a string-formatting reference for the expected line.
module tb_time_uart_tx;

    localparam int DIV = 16;
    localparam int MSG_CYC = 3 + 21 * 10 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [16:0] time_in = '0;
    logic [20:0] date_in = '0;
    logic        send = 1'b0;
    logic        auto_en = 1'b0;
    logic        tx, busy, done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int frame_err = 0;
    int fall_cyc = 0;

    logic [7:0] rx_q[$];
    logic       rx_act = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = '0;

    time_uart_tx #(.CLK_FREQ(16), .BAUD(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .time_in (time_in),
        .date_in (date_in),
        .send    (send),
        .auto_en (auto_en),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // 8N1 receiver sampling mid-bit.
    always @(negedge clk) begin
        if (rst) begin
            rx_act <= 1'b0;
        end else if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act <= 1'b1;
                rx_cnt <= 0;
                if (rx_q.size() == 0) fall_cyc <= cyc;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            for (int j = 1; j <= 8; j++)
                if (rx_cnt + 1 == DIV * j + DIV / 2) rx_sh[j-1] <= tx;
            if (rx_cnt + 1 == DIV * 9 + DIV / 2) begin
                rx_q.push_back(rx_sh);
                if (tx !== 1'b1) frame_err <= frame_err + 1;
                rx_act <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_line(input string tag, input logic [167:0] got, input logic [167:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference line built by decimal formatting, not by digit arithmetic.
    function automatic logic [167:0] exp_line(input int h, input int m, input int s,
                                              input int d, input int mo, input int y);
        string      str;
        logic [167:0] v;
        str = $sformatf("%02d:%02d:%02d %02d.%02d.%04d", h, m, s, d, mo, y);
        v = '0;
        for (int i = 0; i < str.len(); i++) v = {v[159:0], str[i]};
        v = {v[151:0], 8'h0D, 8'h0A};
        return v;
    endfunction

    function automatic logic [167:0] got_line(input int k);
        logic [167:0] v;
        v = '0;
        for (int i = 0; i < 21; i++)
            v = {v[159:0], (k * 21 + i < rx_q.size()) ? rx_q[k * 21 + i] : 8'hxx};
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(input int h, input int m, input int s,
                          input int d, input int mo, input int y);
        time_in = {5'(h), 6'(m), 6'(s)};
        date_in = {5'(d), 4'(mo), 12'(y)};
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk({tag, "_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_bytes(input string tag, input int cnt, input int budget);
        int n;
        n = 0;
        while (rx_q.size() < cnt && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk({tag, "_timeout"}, 32'(rx_q.size()), 32'(cnt));
    endtask

    initial begin
        int t_req, b0, d0;
        int h, m, s, d, mo, y;

        // Reset state
        set_in(13, 5, 9, 28, 2, 2021);
        tick();
        tick();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (4) tick();

        // 1: basic message, latency and busy length
        rx_q.delete();
        b0 = busy_cnt;
        d0 = done_cnt;
        send = 1'b1;
        tick();
        send = 1'b0;
        t_req = cyc;
        wait_idle("s1", MSG_CYC + 100);
        tick();
        chk("s1_tx_fall", 32'(fall_cyc - t_req), 32'd3);
        chk_line("s1_line", got_line(0), exp_line(13, 5, 9, 28, 2, 2021));
        chk("s1_busy_len", 32'(busy_cnt - b0), 32'(MSG_CYC));
        chk("s1_done_cnt", 32'(done_cnt - d0), 32'd1);

        // 2: snapshot holds while inputs change mid-message
        rx_q.delete();
        send = 1'b1;
        tick();
        send = 1'b0;
        wait_bytes("s2", 3, MSG_CYC);
        set_in(0, 0, 0, 28, 2, 2021);
        wait_idle("s2", MSG_CYC + 100);
        tick();
        chk_line("s2_snapshot", got_line(0), exp_line(13, 5, 9, 28, 2, 2021));
        set_in(13, 5, 9, 28, 2, 2021);
        repeat (3) tick();

        // 3: three extra sends while busy coalesce into one more message
        rx_q.delete();
        b0 = busy_cnt;
        d0 = done_cnt;
        send = 1'b1;
        tick();
        send = 1'b0;
        for (int i = 0; i < 3; i++) begin
            repeat (200 + 300 * i) tick();
            send = 1'b1;
            tick();
            send = 1'b0;
        end
        wait_idle("s3", 2 * MSG_CYC + 200);
        repeat (20) tick();
        chk("s3_nbytes", 32'(rx_q.size()), 32'd42);
        chk_line("s3_line0", got_line(0), exp_line(13, 5, 9, 28, 2, 2021));
        chk_line("s3_line1", got_line(1), exp_line(13, 5, 9, 28, 2, 2021));
        chk("s3_busy_len", 32'(busy_cnt - b0), 32'(2 * MSG_CYC));
        chk("s3_done_cnt", 32'(done_cnt - d0), 32'd2);

        // 4: auto mode on seconds change only
        rx_q.delete();
        set_in(10, 20, 58, 28, 2, 2021);
        repeat (3) tick();
        auto_en = 1'b1;
        repeat (3) tick();
        set_in(10, 20, 59, 28, 2, 2021);
        repeat (3) tick();
        wait_idle("s4", MSG_CYC + 100);
        tick();
        chk_line("s4_auto", got_line(0), exp_line(10, 20, 59, 28, 2, 2021));
        b0 = busy_cnt;
        repeat (5000) tick();
        chk("s4_hold_busy", 32'(busy_cnt - b0), 32'd0);
        auto_en = 1'b0;
        set_in(10, 20, 1, 28, 2, 2021);
        repeat (50) tick();
        chk("s4_off_busy", 32'(busy_cnt - b0), 32'd0);

        // 5: reset during byte 7
        rx_q.delete();
        set_in(13, 5, 9, 28, 2, 2021);
        send = 1'b1;
        tick();
        send = 1'b0;
        wait_bytes("s5", 7, MSG_CYC);
        repeat (24) tick();
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s5_tx", 32'(tx), 32'd1);
        chk("s5_busy", 32'(busy), 32'd0);
        repeat (40) tick();
        chk("s5_no_done", 32'(done_cnt - d0), 32'd0);
        rx_q.delete();
        send = 1'b1;
        tick();
        send = 1'b0;
        wait_idle("s5", MSG_CYC + 100);
        tick();
        chk_line("s5_after", got_line(0), exp_line(13, 5, 9, 28, 2, 2021));

        // 6: boundary values
        rx_q.delete();
        set_in(31, 63, 63, 0, 15, 4095);
        send = 1'b1;
        tick();
        send = 1'b0;
        wait_idle("s6a", MSG_CYC + 100);
        tick();
        chk_line("s6_max", got_line(0), exp_line(31, 63, 63, 0, 15, 4095));
        rx_q.delete();
        set_in(0, 0, 0, 1, 1, 0);
        send = 1'b1;
        tick();
        send = 1'b0;
        wait_idle("s6b", MSG_CYC + 100);
        tick();
        chk_line("s6_year0", got_line(0), exp_line(0, 0, 0, 1, 1, 0));

        // Randomized field values
        for (int k = 0; k < 3; k++) begin
            h  = int'($urandom_range(0, 31));
            m  = int'($urandom_range(0, 63));
            s  = int'($urandom_range(0, 63));
            d  = int'($urandom_range(0, 31));
            mo = int'($urandom_range(0, 15));
            y  = int'($urandom_range(0, 4095));
            rx_q.delete();
            set_in(h, m, s, d, mo, y);
            repeat (int'($urandom_range(1, 20))) tick();
            send = 1'b1;
            tick();
            send = 1'b0;
            wait_idle("rnd", MSG_CYC + 100);
            tick();
            chk_line($sformatf("rnd%0d", k), got_line(0), exp_line(h, m, s, d, mo, y));
        end

        chk("framing", 32'(frame_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/time_uart_tx.md
# time_uart_tx

Serial reporter that reads the current time and date from `clockWork` and `date_module` and transmits them as an ASCII line over an 8N1 UART. It is the read-back counterpart to the button/switch set path on the test board: values loaded into the clock are sent to a host terminal. It sits beside the clock UUTs, on the board clock, and its inputs are driven by the `time_out` and `date_out` buses.

## Interface
- `CLK_FREQ`, default 100_000_000: board clock frequency in Hz.
- `BAUD`, default 115200: line rate. Bit period `DIV = CLK_FREQ/BAUD` clock cycles, integer truncation; `DIV` ≥ 2 is required.

Ports:
- `clk`, input, 1: board clock. Single clock domain.
- `rst`, input, 1: synchronous, active-high reset.
- `time_in`, input, 17: {hour[16:12], min[11:6], sec[5:0]}, binary.
- `date_in`, input, 21: {day[20:16], month[15:12], year[11:0]}, binary.
- `send`, input, 1: request one message. Level-sampled every cycle.
- `auto_en`, input, 1: when high, a change of `time_in[5:0]` requests one message.
- `tx`, output, 1: UART line. Idle high.
- `busy`, output, 1: high from request acceptance through the end of the final stop bit.
- `done`, output, 1: one-cycle pulse after a message completes.

## Operation
- Message is 21 bytes, fixed: `HH:MM:SS DD.MM.YYYY` followed by CR (0x0D) and LF (0x0A). Separators are 0x3A `:`, 0x20 space, 0x2E `.`.
- Digit rules:
  - HH, MM, SS, DD and MM each use 2 decimal digits of the binary value. The maximum is 63, so no truncation is needed.
  - Year uses 4 digits, 0000–4095, with leading zeros.
  - Out-of-range values such as hour 31 or month 15 are printed as-is. No clamping.
- Snapshot: `time_in` and `date_in` are latched when a request is accepted. Input changes during the message do not affect it.
- Request sources:
  - `send` high in a cycle.
  - `auto_en` high with `time_in[5:0]` different from its previous-cycle value. A seconds register is kept for this comparison; after reset it is loaded with the current input, so there is no spurious request.
- Pending flag, one deep:
  - A request arriving while `busy` sets `pend`. Multiple requests coalesce.
  - At message end, if `pend` is set, the next message starts and `pend` clears. Its snapshot is taken at that point.
- FSM states and transitions:
  - IDLE → LOAD on a request or `pend`. LOAD captures the snapshot.
  - LOAD → CONV. CONV registers the 21 ASCII bytes.
  - CONV → START.
  - START → DATA: 8 bits, LSB first.
  - DATA → STOP.
  - STOP → START if the byte index is below 20; otherwise → IDLE and pulse `done`.
- There is no idle gap between bytes: the next start bit immediately follows the previous stop bit.
- Simultaneous events:
  - A request in the same cycle as message end sets `pend`, and that request is served.
  - `send` and a seconds-change request in the same cycle count as one request.

## Timing
- Reset values: `tx` = 1, `busy` = 0, `done` = 0, `pend` = 0, FSM = IDLE, bit counter = 0, byte index = 0, divider = 0.
- Request sampled at edge N: `busy` is 1 from edge N.
- Snapshot is captured at edge N+1 (LOAD).
- ASCII bytes are valid at edge N+2 (CONV).
- `tx` falls to the start bit at edge N+3.
- Each start, data and stop bit lasts exactly `DIV` cycles.
- One message spans 21·10·`DIV` cycles from the `tx` fall to the end of the final stop bit.
- At the end of the final stop bit, `busy` drops and `done` pulses for one cycle on the same edge.
- If `pend` is set, `busy` stays high and the LOAD of the next message occurs on that edge instead.
- Reset asserted mid-operation:
  - At the next edge, `tx` = 1, `busy` = 0, `pend` is cleared, and `done` does not pulse.
  - The partial byte is abandoned.

## Test plan
Use `CLK_FREQ` = 16 and `BAUD` = 1 (`DIV` = 16) for all scenarios.
1. Basic message: time 13:05:09, date 28.02.2021, pulse `send`. Required response:
   - `tx` falls 3 cycles after `send` is sampled.
   - Decoded bytes are `13:05:09 28.02.2021`, CR, LF.
   - `busy` is high for 3 + 3360 cycles.
   - `done` pulses exactly once.
2. Snapshot: same stimulus as scenario 1, then change the time to 00:00:00 during byte 3. The line is still `13:05:09 …`.
3. Pending coalescing: pulse `send` three times while `busy`. Required response:
   - Exactly two messages in total, back to back.
   - `busy` stays high between them.
   - `done` pulses twice.
4. Auto mode:
   - `auto_en` = 1, seconds 58 → 59: one message containing `…:59 …`.
   - Seconds held constant for 5000 cycles: no message.
   - `auto_en` = 0 with a seconds change: no message.
5. Reset mid-byte: assert `rst` for one cycle during byte 7. Required response:
   - `tx` = 1 and `busy` = 0 on the next cycle.
   - No `done` pulse.
   - A later `send` produces a complete, correct message.
6. Boundary values:
   - Hour 31, min 63, sec 63, day 0, month 15, year 4095 gives `31:63:63 00.15.4095`.
   - Year 0 gives `0000`.
